// File: rtl/i2c_pkg.sv
// Shared I2C definitions: debug state encodings, R/W bit values and default address.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_RX        = 4'd3,
    ST_RX_ACK    = 4'd4,
    ST_TX        = 4'd5,
    ST_TX_ACKCHK = 4'd6,
    ST_WAIT_STOP = 4'd7
  } state_t;

  localparam logic       READ         = 1'b1;
  localparam logic       WRITE        = 1'b0;
  localparam logic [6:0] DEFAULT_ADDR = 7'h2d;

endpackage

// File: rtl/i2c_slave_if.sv
// Bus wires plus byte-level strobe interface between the I2C target and local logic.
interface i2c_slave_if;
  logic       sclk;
  logic       sda_in;
  logic       sda_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       busy;
  logic [3:0] state;

  modport slave (
    input  sclk, sda_in, tx_data,
    output sda_out, rx_data, rx_valid, tx_load, busy, state
  );

  modport master (
    output sclk, sda_in, tx_data,
    input  sda_out, rx_data, rx_valid, tx_load, busy, state
  );
endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-stage synchronizer preset high, followed by a rise/fall detector on the synced level.
module i2c_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: oversampled START/STOP detection, 7-bit address match, byte receive with ACK
// and byte transmit from a local source with master ACK/NACK handling.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = DEFAULT_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  i2c_slave_if.slave     bus
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.sclk),
    .level (scl_s),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.sda_in),
    .level (sda_s),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       phase_q, phase_d;
  logic       sda_q, sda_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       busy_q, busy_d;

  logic       start_cond, stop_cond;
  logic [7:0] byte_in;

  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;
  assign byte_in    = {shift_q[6:0], sda_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rw_q       <= WRITE;
      phase_q    <= 1'b0;
      sda_q      <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      sda_q      <= sda_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    sda_d      = sda_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    busy_d     = busy_q;

    // Bus conditions override whatever the data path is doing.
    if (start_cond) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      sda_d   = 1'b1;
      phase_d = 1'b0;
    end else if (stop_cond) begin
      state_d = ST_IDLE;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: sda_d = 1'b1;

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                rw_d    = byte_in[0] ? READ : WRITE;
                busy_d  = 1'b1;
                phase_d = 1'b0;
                state_d = ST_ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = ST_WAIT_STOP;
              end
            end
          end
        end

        // phase_q marks that the ACK low is already on the wire.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_d   = 1'b0;
              phase_d = 1'b1;
            end else if (rw_q == READ) begin
              tx_load_d = 1'b1;
              sda_d     = bus.tx_data[7];
              shift_d   = {bus.tx_data[6:0], 1'b0};
              cnt_d     = '0;
              state_d   = ST_TX;
            end else begin
              sda_d   = 1'b1;
              cnt_d   = '0;
              state_d = ST_RX;
            end
          end
        end

        ST_RX: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              phase_d    = 1'b0;
              state_d    = ST_RX_ACK;
            end
          end
        end

        ST_RX_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_d   = 1'b0;
              phase_d = 1'b1;
            end else begin
              sda_d   = 1'b1;
              cnt_d   = '0;
              state_d = ST_RX;
            end
          end
        end

        // Bit 7 went out on entry, so seven more falls shift bits 6..0 and the eighth releases.
        ST_TX: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_d   = 1'b1;
              cnt_d   = '0;
              phase_d = 1'b0;
              state_d = ST_TX_ACKCHK;
            end else begin
              sda_d   = shift_q[7];
              shift_d = {shift_q[6:0], 1'b0};
              cnt_d   = cnt_q + 3'd1;
            end
          end
        end

        ST_TX_ACKCHK: begin
          if (scl_rise) begin
            if (sda_s) begin
              sda_d   = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_WAIT_STOP;
            end else begin
              phase_d = 1'b1;
            end
          end else if (scl_fall && phase_q) begin
            tx_load_d = 1'b1;
            sda_d     = bus.tx_data[7];
            shift_d   = {bus.tx_data[6:0], 1'b0};
            cnt_d     = '0;
            state_d   = ST_TX;
          end
        end

        ST_WAIT_STOP: begin
          sda_d  = 1'b1;
          busy_d = 1'b0;
        end

        default: begin
          sda_d   = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sda_out  = sda_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_load  = tx_load_q;
  assign bus.busy     = busy_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: bus-level master tasks, write vector table and read/abort sequences.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int H = 8;  // clk cycles per sclk phase

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_slave_if bif();

  i2c_slave #(.SLAVE_ADDR(7'h2d), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int   total = 0;
  int   bad = 0;
  int   rx_cnt = 0;
  int   tx_cnt = 0;
  int   overlap = 0;
  logic sda_low_seen = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  typedef struct {
    logic [7:0] addr_b;
    logic [7:0] data_b;
    logic       exp_addr_ack;
    logic       exp_data_ack;
    logic [3:0] exp_state_mid;
    logic       exp_busy_mid;
    int         exp_rx;
  } wvec_t;

  wvec_t vecs[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic seen);
    clks(H/2);
    bif.sda_in = b;
    clks(H/2);
    bif.sclk = 1'b1;
    clks(H/2);
    seen = bif.sda_out;
    clks(H/2);
    bif.sclk = 1'b0;
  endtask

  task automatic bus_start();
    clks(H/2);
    bif.sda_in = 1'b1;
    clks(H/2);
    bif.sclk = 1'b1;
    clks(H);
    bif.sda_in = 1'b0;
    clks(H);
    bif.sclk = 1'b0;
  endtask

  task automatic bus_stop();
    clks(H/2);
    bif.sda_in = 1'b0;
    clks(H/2);
    bif.sclk = 1'b1;
    clks(H);
    bif.sda_in = 1'b1;
    clks(H);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
  endtask

  // Scoreboard side: every rx_valid pops the byte the bench expects next.
  always @(negedge clk) begin
    if (!rst) begin
      if (bif.rx_valid) begin
        rx_cnt++;
        if (rx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got %0h want none", bif.rx_data);
        end else begin
          check("rx_data", {24'd0, bif.rx_data}, {24'd0, rx_q.pop_front()});
        end
      end
      if (bif.tx_load) tx_cnt++;
      if (bif.rx_valid && bif.tx_load) overlap++;
      if (!bif.sda_out) sda_low_seen = 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, s;
    logic [7:0] b;
    int         r0, t0;
    logic [7:0] partial;

    vecs[0] = '{8'h5a, 8'hA5, 1'b1, 1'b1, 4'(ST_RX),        1'b1, 1};
    vecs[1] = '{8'h5a, 8'h00, 1'b1, 1'b1, 4'(ST_RX),        1'b1, 1};
    vecs[2] = '{8'h5c, 8'hFF, 1'b0, 1'b0, 4'(ST_WAIT_STOP), 1'b0, 0};
    vecs[3] = '{8'h2d, 8'h5a, 1'b0, 1'b0, 4'(ST_WAIT_STOP), 1'b0, 0};

    bif.sclk = 1'b1;
    bif.sda_in = 1'b1;
    bif.tx_data = 8'h00;

    clks(2);
    check("rst_sda_out",  {31'd0, bif.sda_out},  32'd1);
    check("rst_rx_data",  {24'd0, bif.rx_data},  32'd0);
    check("rst_rx_valid", {31'd0, bif.rx_valid}, 32'd0);
    check("rst_tx_load",  {31'd0, bif.tx_load},  32'd0);
    check("rst_busy",     {31'd0, bif.busy},     32'd0);
    check("rst_state",    {28'd0, bif.state},    32'd0);

    rst = 1'b0;
    clks(20);
    check("startup_state", {28'd0, bif.state}, 32'(ST_IDLE));
    check("startup_busy",  {31'd0, bif.busy},  32'd0);

    for (int v = 0; v < 4; v++) begin
      r0 = rx_cnt;
      sda_low_seen = 1'b0;
      if (vecs[v].exp_addr_ack) rx_q.push_back(vecs[v].data_b);
      bus_start();
      write_byte(vecs[v].addr_b, ack);
      check("addr_ack", {31'd0, ack}, {31'd0, vecs[v].exp_addr_ack});
      clks(4);
      check("state_mid", {28'd0, bif.state}, {28'd0, vecs[v].exp_state_mid});
      check("busy_mid",  {31'd0, bif.busy},  {31'd0, vecs[v].exp_busy_mid});
      write_byte(vecs[v].data_b, ack);
      check("data_ack", {31'd0, ack}, {31'd0, vecs[v].exp_data_ack});
      bus_stop();
      clks(4);
      check("rx_pulses",  32'(rx_cnt - r0), 32'(vecs[v].exp_rx));
      check("busy_end",   {31'd0, bif.busy},  32'd0);
      check("state_end",  {28'd0, bif.state}, 32'(ST_IDLE));
      if (!vecs[v].exp_addr_ack) check("sda_never_low", {31'd0, sda_low_seen}, 32'd0);
    end

    // Read of two bytes: ACK the first, NACK the second.
    t0 = tx_cnt;
    bif.tx_data = 8'h3C;
    tx_q.push_back(8'h3C);
    bus_start();
    write_byte(8'h5b, ack);
    check("rd_addr_ack", {31'd0, ack}, 32'd1);
    read_byte(b);
    bif.tx_data = 8'hC3;
    tx_q.push_back(8'hC3);
    bus_bit(1'b0, s);
    check("rd_byte1", {24'd0, b}, {24'd0, tx_q.pop_front()});
    read_byte(b);
    check("rd_byte2", {24'd0, b}, {24'd0, tx_q.pop_front()});
    bus_bit(1'b1, s);
    clks(2);
    check("rd_nack_state", {28'd0, bif.state},   32'(ST_WAIT_STOP));
    check("rd_nack_sda",   {31'd0, bif.sda_out}, 32'd1);
    check("rd_loads",      32'(tx_cnt - t0),     32'd2);
    bus_stop();
    clks(4);
    check("rd_state_end", {28'd0, bif.state}, 32'(ST_IDLE));

    // Repeated START from a write into a read.
    r0 = rx_cnt;
    rx_q.push_back(8'h11);
    bus_start();
    write_byte(8'h5a, ack);
    write_byte(8'h11, ack);
    check("rs_data_ack", {31'd0, ack}, 32'd1);
    bus_start();
    check("rs_state_addr", {28'd0, bif.state}, 32'(ST_ADDR));
    bif.tx_data = 8'h96;
    tx_q.push_back(8'h96);
    write_byte(8'h5b, ack);
    check("rs_rd_addr_ack", {31'd0, ack}, 32'd1);
    check("rs_rx_data",  {24'd0, bif.rx_data}, 32'h11);
    check("rs_rx_pulses", 32'(rx_cnt - r0), 32'd1);
    read_byte(b);
    check("rs_rd_byte", {24'd0, b}, {24'd0, tx_q.pop_front()});
    bus_bit(1'b1, s);
    bus_stop();
    clks(4);
    check("rs_state_end", {28'd0, bif.state}, 32'(ST_IDLE));

    // Reset after four data bits of a write, then a clean write.
    r0 = rx_cnt;
    partial = 8'h77;
    bus_start();
    write_byte(8'h5a, ack);
    for (int i = 7; i >= 4; i--) bus_bit(partial[i], s);
    check("pre_rst_state", {28'd0, bif.state}, 32'(ST_RX));
    rst = 1'b1;
    #1;
    check("rst_mid_sda",   {31'd0, bif.sda_out}, 32'd1);
    check("rst_mid_state", {28'd0, bif.state},   32'(ST_IDLE));
    clks(2);
    rst = 1'b0;
    bif.sda_in = 1'b1;
    clks(H);
    bif.sclk = 1'b1;
    clks(H);
    check("rst_no_rx", 32'(rx_cnt - r0), 32'd0);
    check("post_rst_state", {28'd0, bif.state}, 32'(ST_IDLE));
    rx_q.push_back(8'h77);
    bus_start();
    write_byte(8'h5a, ack);
    check("post_rst_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h77, ack);
    check("post_rst_data_ack", {31'd0, ack}, 32'd1);
    bus_stop();
    clks(4);
    check("post_rst_rx_pulses", 32'(rx_cnt - r0), 32'd1);
    check("post_rst_rx_data",  {24'd0, bif.rx_data}, 32'h77);

    check("strobe_overlap", 32'(overlap), 32'd0);
    check("rx_q_drained",   32'(rx_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
